// File: rtl/keypad_seq_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the keypad sequence entry block:
//               FSM state encoding, matrix geometry, row decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_PRESS_DB = 2'd1,
        KP_HELD     = 2'd2,
        KP_REL_DB   = 2'd3
    } kp_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    // Rows are active-low: valid only when exactly one row is pulled low,
    // idx is the position of that low row.
    function automatic row_hit_t row_onehot_idx(input logic [NUM_ROWS-1:0] rows);
        row_hit_t hit;
        int       n_low;
        hit   = '0;
        n_low = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) begin
                n_low   = n_low + 1;
                hit.idx = 2'(i);
            end
        end
        hit.valid = (n_low == 1);
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_seq_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_seq_entry_if
// Description : Keypad pins plus the digit-sequence / key-event outputs.
//               master = keypad/consumer side, slave = keypad_seq_entry.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_seq_entry_if
    import keypad_pkg::*;
#(
    parameter int N = 32
);
    logic [NUM_ROWS-1:0] row;
    logic                clr;
    logic [NUM_COLS-1:0] col;
    logic [N-1:0]        seq;
    logic [3:0]          key_code;
    logic                key_valid;

    modport master (output row, clr, input col, seq, key_code, key_valid);
    modport slave  (input row, clr, output col, seq, key_code, key_valid);
endinterface
`default_nettype wire

// File: rtl/keypad_seq_entry_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous level inputs.
//               Resets to all ones (idle level of pulled-up keypad rows).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/keypad_seq_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_seq_entry
// Description : Scans a 4x4 hex keypad, debounces press and release, and
//               shifts each accepted key into an N-bit digit sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_seq_entry
    import keypad_pkg::*;
#(
    parameter int N        = 32,
    parameter int WIDTH    = 4,
    parameter int SCAN_DIV = 50_000,
    parameter int DEBOUNCE = 8
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst_n,
    keypad_seq_entry_if.slave  bus
);
    localparam int c_TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DB_W   = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] c_ST_SCAN     = 2'(KP_SCAN);
    localparam logic [1:0] c_ST_PRESS_DB = 2'(KP_PRESS_DB);
    localparam logic [1:0] c_ST_HELD     = 2'(KP_HELD);
    localparam logic [1:0] c_ST_REL_DB   = 2'(KP_REL_DB);

    logic [NUM_ROWS-1:0] w_row_s;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [1:0]          r_col_idx;
    logic [1:0]          w_col_idx_nxt;
    logic [NUM_COLS-1:0] r_col;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_DB_W-1:0]   w_db_nxt;
    logic [NUM_ROWS-1:0] r_pattern;
    logic                w_latch;
    logic                w_col_adv;
    logic                w_commit;
    logic                w_all_high;
    row_hit_t            w_hit;
    logic [3:0]          w_key;
    logic [N-1:0]        r_seq;
    logic [3:0]          r_key_code;
    logic                r_key_valid;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .i_d   (bus.row),
        .o_q   (w_row_s)
    );

    assign w_tick     = (r_tick_cnt == c_TICK_W'(SCAN_DIV - 1));
    assign w_all_high = &w_row_s;
    assign w_hit      = row_onehot_idx(w_row_s);
    assign w_key      = {w_hit.idx, r_col_idx};

    // Free-running scan tick divider
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    // Scan/debounce decisions, evaluated only on tick cycles
    always_comb begin
        w_state_nxt = r_state;
        w_db_nxt    = r_db_cnt;
        w_col_adv   = 1'b0;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        if (w_tick) begin
            case (r_state)
                c_ST_SCAN: begin
                    // Idle rows and ghosted multi-row patterns both keep scanning
                    if (w_hit.valid) begin
                        w_latch     = 1'b1;
                        w_db_nxt    = c_DB_W'(1);
                        w_state_nxt = c_ST_PRESS_DB;
                    end else begin
                        w_col_adv = 1'b1;
                    end
                end
                c_ST_PRESS_DB: begin
                    if (w_row_s == r_pattern) begin
                        w_db_nxt = r_db_cnt + c_DB_W'(1);
                        if (r_db_cnt == c_DB_W'(DEBOUNCE - 1)) begin
                            w_commit    = 1'b1;
                            w_state_nxt = c_ST_HELD;
                        end
                    end else begin
                        w_col_adv   = 1'b1;
                        w_state_nxt = c_ST_SCAN;
                    end
                end
                c_ST_HELD: begin
                    if (w_all_high) begin
                        w_db_nxt    = c_DB_W'(1);
                        w_state_nxt = c_ST_REL_DB;
                    end
                end
                c_ST_REL_DB: begin
                    if (w_all_high) begin
                        w_db_nxt = r_db_cnt + c_DB_W'(1);
                        if (r_db_cnt == c_DB_W'(DEBOUNCE - 1)) begin
                            w_col_adv   = 1'b1;
                            w_state_nxt = c_ST_SCAN;
                        end
                    end else begin
                        w_state_nxt = c_ST_HELD;
                    end
                end
                default: w_state_nxt = c_ST_SCAN;
            endcase
        end
    end

    assign w_col_idx_nxt = w_col_adv ? (r_col_idx + 2'd1) : r_col_idx;

    // FSM state, debounce counter, latched row pattern and column drive
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= c_ST_SCAN;
            r_db_cnt  <= '0;
            r_pattern <= '1;
            r_col_idx <= 2'd0;
            r_col     <= 4'b1110;
        end else begin
            r_state   <= w_state_nxt;
            r_db_cnt  <= w_db_nxt;
            r_col_idx <= w_col_idx_nxt;
            r_col     <= ~(4'b0001 << w_col_idx_nxt);
            if (w_latch) begin
                r_pattern <= w_row_s;
            end
        end
    end

    // Commit path: key event outputs and the digit shift register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_seq       <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_commit;
            if (w_commit) begin
                r_key_code <= w_key;
            end
            // Clear beats a simultaneous commit for the sequence only
            if (bus.clr) begin
                r_seq <= '0;
            end else if (w_commit) begin
                r_seq <= {r_seq[N-WIDTH-1:0], WIDTH'(w_key)};
            end
        end
    end

    assign bus.col       = r_col;
    assign bus.seq       = r_seq;
    assign bus.key_code  = r_key_code;
    assign bus.key_valid = r_key_valid;
endmodule
`default_nettype wire

// File: tb/tb_keypad_seq_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_seq_entry
// Description : Directed self-checking bench with a behavioural 4x4 keypad
//               (key code r*4+c connects row r to column c when pressed).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_seq_entry;
    localparam int N        = 32;
    localparam int WIDTH    = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = '0;
    logic [3:0]  kp_row;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          kv_count = 0;

    keypad_seq_entry_if #(.N(N)) bus ();

    keypad_seq_entry #(
        .N        (N),
        .WIDTH    (WIDTH),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        kp_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            kp_row[r] = ~|(pressed[r*4 +: 4] & ~bus.col);
        end
    end
    assign bus.row = kp_row;

    // Count key_valid pulses
    always @(posedge clk) begin
        if (bus.key_valid === 1'b1) kv_count = kv_count + 1;
    end

    task automatic wait_col_enter(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        ok   = 1'b0;
        prev = bus.col;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.col === target && prev !== target) begin
                ok = 1'b1;
                break;
            end
            prev = bus.col;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        int         kv0;
        rst_n   = 1'b0;
        bus.clr = 1'b0;
        pressed = '0;
        repeat (4) @(negedge clk);
        n_tests++; if (bus.col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected 1110", bus.col); end
        n_tests++; if (bus.seq !== 32'h0) begin n_fail++; $display("FAIL reset_seq: got %h expected 0", bus.seq); end
        n_tests++; if (bus.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h expected 0", bus.key_code); end
        n_tests++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", bus.key_valid); end
        kv0   = kv_count;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            n_tests++;
            if (bus.col !== exp_col) begin n_fail++; $display("FAIL scan_col[%0d]: got %b expected %b", i, bus.col, exp_col); end
            @(negedge clk);
        end
        n_tests++; if (kv_count != kv0) begin n_fail++; $display("FAIL scan_no_pulse: got %0d pulses expected 0", kv_count - kv0); end
        n_tests++; if (bus.seq !== 32'h0) begin n_fail++; $display("FAIL scan_seq: got %h expected 0", bus.seq); end
    endtask

    task automatic test_single_press();
        int         pulses;
        logic [3:0] got_code;
        logic [3:0] got_col;
        bit         held_ok;
        bit         moved;
        pulses   = 0;
        got_code = 4'hx;
        got_col  = 4'hx;
        pressed[9] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.key_valid === 1'b1) begin
                pulses++;
                got_code = bus.key_code;
                got_col  = bus.col;
            end
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL press_pulses: got %0d expected 1", pulses); end
        n_tests++; if (got_code !== 4'h9) begin n_fail++; $display("FAIL press_key_code: got %h expected 9", got_code); end
        n_tests++; if (got_col !== 4'b1101) begin n_fail++; $display("FAIL press_col_at_commit: got %b expected 1101", got_col); end
        n_tests++; if (bus.col !== 4'b1101) begin n_fail++; $display("FAIL press_col_held: got %b expected 1101", bus.col); end
        n_tests++; if (bus.seq !== 32'h0000_0009) begin n_fail++; $display("FAIL press_seq: got %h expected 00000009", bus.seq); end
        pressed[9] = 1'b0;
        held_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.col !== 4'b1101) held_ok = 1'b0;
        end
        n_tests++; if (!held_ok) begin n_fail++; $display("FAIL release_col_frozen: got %b expected 1101", bus.col); end
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.col === 4'b1011) begin moved = 1'b1; break; end
        end
        n_tests++; if (!moved) begin n_fail++; $display("FAIL release_resume: got col %b expected 1011", bus.col); end
    endtask

    task automatic test_seq_fill();
        int keys [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        bit seen;
        for (int k = 0; k < 10; k++) begin
            pressed[keys[k]] = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.key_valid === 1'b1) begin seen = 1'b1; break; end
            end
            n_tests++;
            if (!seen) begin
                n_fail++; $display("FAIL fill_key%0d: got no key_valid expected pulse", keys[k]);
            end else if (bus.key_code !== 4'(keys[k])) begin
                n_fail++; $display("FAIL fill_key%0d: got code %h expected %h", keys[k], bus.key_code, 4'(keys[k]));
            end
            pressed[keys[k]] = 1'b0;
            repeat (24) @(negedge clk);
            if (k == 7) begin
                n_tests++; if (bus.seq !== 32'h1234_5678) begin n_fail++; $display("FAIL fill_seq8: got %h expected 12345678", bus.seq); end
            end
        end
        n_tests++; if (bus.seq !== 32'h3456_7890) begin n_fail++; $display("FAIL fill_seq10: got %h expected 34567890", bus.seq); end
    endtask

    task automatic test_bounce();
        bit ok;
        int kv0;
        kv0 = kv_count;
        wait_col_enter(4'b1110, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bounce_align: got col %b expected 1110", bus.col); end
        pressed[0] = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (bus.col !== 4'b1110) begin n_fail++; $display("FAIL bounce_detect_hold: got %b expected 1110", bus.col); end
        pressed[0] = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (bus.col !== 4'b1101) begin n_fail++; $display("FAIL bounce_abort_advance: got %b expected 1101", bus.col); end
        pressed[0] = 1'b1;
        repeat (4) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (32) @(negedge clk);
        n_tests++; if (kv_count != kv0) begin n_fail++; $display("FAIL bounce_no_commit: got %0d pulses expected 0", kv_count - kv0); end
        n_tests++; if (bus.seq !== 32'h3456_7890) begin n_fail++; $display("FAIL bounce_seq: got %h expected 34567890", bus.seq); end
    endtask

    task automatic test_ghosting();
        int         kv0;
        int         trans;
        bit         saw_col2;
        logic [3:0] prev;
        kv0      = kv_count;
        trans    = 0;
        saw_col2 = 1'b0;
        pressed[2] = 1'b1;
        pressed[6] = 1'b1;
        prev = bus.col;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (bus.col !== prev) trans++;
            if (bus.col === 4'b1011) saw_col2 = 1'b1;
            prev = bus.col;
        end
        n_tests++; if (trans != 12) begin n_fail++; $display("FAIL ghost_col_steps: got %0d expected 12", trans); end
        n_tests++; if (!saw_col2) begin n_fail++; $display("FAIL ghost_col2_visited: got 0 expected 1"); end
        n_tests++; if (kv_count != kv0) begin n_fail++; $display("FAIL ghost_no_commit: got %0d pulses expected 0", kv_count - kv0); end
        pressed = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_clr_and_reset();
        bit ok;
        int kv0;
        // clr coinciding with the commit edge of key A
        wait_col_enter(4'b1011, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL clr_align: got col %b expected 1011", bus.col); end
        pressed[10] = 1'b1;
        repeat (11) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.seq !== 32'h0) begin n_fail++; $display("FAIL clr_seq: got %h expected 0", bus.seq); end
        n_tests++; if (bus.key_valid !== 1'b1) begin n_fail++; $display("FAIL clr_key_valid: got %b expected 1", bus.key_valid); end
        n_tests++; if (bus.key_code !== 4'hA) begin n_fail++; $display("FAIL clr_key_code: got %h expected a", bus.key_code); end
        bus.clr = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL clr_pulse_width: got %b expected 0", bus.key_valid); end
        pressed[10] = 1'b0;
        repeat (24) @(negedge clk);

        // Reset while debouncing a press of key 3
        wait_col_enter(4'b0111, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_align: got col %b expected 0111", bus.col); end
        pressed[3] = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (bus.col !== 4'b0111) begin n_fail++; $display("FAIL rst_in_press_db: got %b expected 0111", bus.col); end
        kv0   = kv_count;
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.col !== 4'b1110) begin n_fail++; $display("FAIL rst_col: got %b expected 1110", bus.col); end
        pressed[3] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_tests++; if (kv_count != kv0) begin n_fail++; $display("FAIL rst_no_commit: got %0d pulses expected 0", kv_count - kv0); end
        n_tests++; if (bus.seq !== 32'h0) begin n_fail++; $display("FAIL rst_seq: got %h expected 0", bus.seq); end
        n_tests++; if (bus.key_code !== 4'h0) begin n_fail++; $display("FAIL rst_key_code: got %h expected 0", bus.key_code); end
    endtask

    initial begin
        bus.clr = 1'b0;
        test_reset();
        test_single_press();
        test_seq_fill();
        test_bounce();
        test_ghosting();
        test_clr_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/keypad_seq_entry.md
# keypad_seq_entry

Input-side companion to the seven-segment marquee. It scans a 4x4 hex matrix keypad, debounces presses, and shifts each accepted key into an N-bit digit sequence. That sequence is the `seq` word the marquee displays and rotates. It runs in the system clock domain and replaces the slide-switch source of `seq`.

## Interface
- `N`, 32: sequence width in bits; a multiple of `WIDTH`, at least 8.
- `WIDTH`, 4: bits per digit (hex nibble).
- `SCAN_DIV`, 50_000: clocks per scan tick (1 ms at 50 MHz); 4 for simulation.
- `DEBOUNCE`, 8: consecutive identical tick samples required to accept a press or a release; at least 2; 3 for simulation.
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, synchronous and active-low.
- `row` in 4: keypad rows, active-low (pulled up externally), asynchronous to `sys_clk`.
- `clr` in 1: synchronous clear of `seq`.
- `col` out 4: column drive, active-low one-hot.
- `seq` out N: digit sequence; newest digit in bits `[WIDTH-1:0]`.
- `key_code` out 4: last accepted key.
- `key_valid` out 1: one-cycle pulse when a key is accepted.

## Operation
- **Row synchronizer:** `row` passes through a 2-flop synchronizer; all logic uses the synchronized copy `row_s`.
- **Tick counter:** counts 0..`SCAN_DIV`-1 and wraps. `tick` is high while the count equals `SCAN_DIV`-1. Every FSM action below happens only on `tick` cycles.
- **Column index:** `col_idx` is 2 bits. `col = ~(4'b0001 << col_idx)`.
- **Key encoding:** `key_code = {row_idx, col_idx}`, where `row_idx` is the position of the single low bit in `row_s`.
- **FSM states:** SCAN, PRESS_DB, HELD, REL_DB.
  - **SCAN:**
    - On a tick with `row_s` all ones, advance `col_idx`, wrapping 3 to 0.
    - On a tick with exactly one low bit, latch that pattern, set `db_cnt`=1, hold `col_idx`, go to PRESS_DB.
    - On a tick with more than one low bit (ghosting), treat as no key: advance `col_idx` and stay in SCAN.
  - **PRESS_DB:**
    - On a tick with `row_s` equal to the latched pattern, increment `db_cnt`.
    - When `db_cnt` reaches `DEBOUNCE`, commit and go to HELD.
    - On a tick with any other pattern, return to SCAN and advance `col_idx`. Nothing is committed.
  - **HELD:** column stays frozen. On a tick with `row_s` all ones, set `db_cnt`=1 and go to REL_DB.
  - **REL_DB:**
    - On a tick with `row_s` all ones, increment `db_cnt`. At `DEBOUNCE`, go to SCAN and advance `col_idx`.
    - On a tick with any low bit, return to HELD.
- **Commit** (a single clock edge):
  - `key_code` is loaded.
  - `key_valid`=1 for exactly one cycle.
  - `seq <= {seq[N-WIDTH-1:0], key_code}`. The oldest digit is discarded, with no saturation.
- **`clr`:** on the next edge, `seq` becomes 0.
  - If `clr` coincides with a commit, `clr` wins for `seq` (`seq`=0).
  - `key_code` and `key_valid` still update as for a normal commit.
  - `clr` does not affect the FSM.
- **Reset values:** state SCAN, `col_idx`=0, `col`=4'b1110, tick counter 0, `db_cnt` 0, synchronizer flops all ones, `seq`=0, `key_code`=0, `key_valid`=0.
- **Reset mid-operation:** an in-progress press is abandoned with no commit. The held key must be released and pressed again to be accepted.

## Timing
- **Pin to FSM:** a change on `row` is visible 2 clocks later.
- **Column dwell:** each column is driven for exactly `SCAN_DIV` clocks while scanning.
- **Press latency:** commit occurs (`DEBOUNCE`-1)·`SCAN_DIV` clocks after the detecting tick. `key_valid` and `seq` are valid on the following cycle.
- **Holding a key:** produces exactly one commit; there is no auto-repeat.
- **Minimum release time:** a release must last `DEBOUNCE` ticks before the next key is accepted.
- **Outputs:** all outputs are registered; none combinational from `row`.

## Structure
- **Package `keypad_pkg`:**
  - FSM state enum.
  - `NUM_COLS`=4 and `NUM_ROWS`=4.
  - Function `row_onehot_idx`, which returns the index and a valid flag meaning exactly one bit is low.
- **Sub-module `sync_2ff`:** parameterized width, reset value all ones, synchronous active-low reset.
- Tick counter, FSM and sequence register live in `keypad_seq_entry`.

## Test plan
Simulation parameters: `SCAN_DIV`=4, `DEBOUNCE`=3, N=32.
1. **Reset and scan:** release reset with no key pressed. `col` cycles 1110, 1101, 1011, 0111, 1110, each held 4 clocks. `seq`=0 and `key_valid` never pulses.
2. **Single press:** press row 2 on column 1 and hold 40 clocks. Exactly one `key_valid` pulse, `key_code`=4'h9, `seq`=32'h0000_0009. `col` stays at 1101 until release plus 3 ticks.
3. **Sequence fill and wrap:** enter keys 1..9 then 0.
   - After 8 keys, `seq`=32'h1234_5678.
   - After 10 keys, `seq`=32'h3456_7890.
4. **Bounce:** on column 0, toggle row 0 low for 1 tick, high for 1 tick, low for 1 tick, then high. No commit; scanning resumes.
5. **Ghosting:** rows 0 and 1 both low on column 2. No commit, and `col_idx` keeps advancing.
6. **`clr` and reset:**
   - Assert `clr` on the same cycle as a commit of 4'hA: `seq`=0, `key_valid` pulses, `key_code`=4'hA.
   - Assert reset in PRESS_DB: no pulse, `col`=1110.
